// File: rtl/seq_stream_ctrl.sv
// Plays a latched bit pattern, MSB first, into a serial sequence detector and
// collects the detector's Moore output after every bit: hit count and first-hit index.
module seq_stream_ctrl #(
  parameter int PAT_W    = 16,
  parameter int CNT_W    = 5,
  parameter int TICK_DIV = 1,
  parameter int IDX_W    = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [IDX_W:0]   length,
  input  logic             det_out,
  output logic             w,
  output logic             det_en,
  output logic             det_clr,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hit_count,
  output logic             hit_valid,
  output logic [IDX_W-1:0] first_hit_idx
);
  // start is a level request with no ready: it is taken only in S_IDLE, so a
  // held start re-triggers on every IDLE cycle and is ignored everywhere else.
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [IDX_W:0]    LEN_MAX   = (IDX_W+1)'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SEND, S_SAMPLE, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [PAT_W-1:0]   shift_reg;
  logic [IDX_W:0]     remaining;
  logic [TICK_W-1:0]  tick;
  logic [IDX_W-1:0]   bit_idx;
  logic [IDX_W:0]     len_clamped;
  logic               remaining_last;

  assign len_clamped    = (length > LEN_MAX) ? LEN_MAX : length;
  assign remaining_last = (remaining == (IDX_W+1)'(1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    w         = 1'b0;
    det_en    = 1'b0;
    det_clr   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = (len_clamped == '0) ? S_DONE : S_CLEAR;
      end
      S_CLEAR: begin
        det_clr   = 1'b1;
        busy      = 1'b1;
        state_nxt = S_SEND;
      end
      S_SEND: begin
        w    = shift_reg[PAT_W-1];
        busy = 1'b1;
        if (tick == TICK_LAST) begin
          det_en    = 1'b1;
          state_nxt = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        w         = shift_reg[PAT_W-1];
        busy      = 1'b1;
        state_nxt = remaining_last ? S_DONE : S_SEND;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      shift_reg     <= '0;
      remaining     <= '0;
      tick          <= '0;
      bit_idx       <= '0;
      hit_count     <= '0;
      hit_valid     <= 1'b0;
      first_hit_idx <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            shift_reg     <= pattern;
            remaining     <= len_clamped;
            bit_idx       <= '0;
            hit_count     <= '0;
            hit_valid     <= 1'b0;
            first_hit_idx <= '0;
          end
        end
        S_CLEAR: tick <= '0;
        S_SEND:  tick <= tick + TICK_W'(1);
        S_SAMPLE: begin
          // det_out here already reflects the advance made on the det_en edge
          if (det_out) begin
            if (hit_count != CNT_MAX) hit_count <= hit_count + CNT_W'(1);
            if (!hit_valid) begin
              hit_valid     <= 1'b1;
              first_hit_idx <= bit_idx;
            end
          end
          shift_reg <= {shift_reg[PAT_W-2:0], 1'b0};
          bit_idx   <= bit_idx + IDX_W'(1);
          remaining <= remaining - (IDX_W+1)'(1);
          tick      <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_stream_ctrl.sv
// Bench for seq_stream_ctrl: two instances (default and CNT_W=2/TICK_DIV=2), each
// driving a 7-state detector, checked against a bit-window reference model.
module tb_seq_stream_ctrl;
  localparam int PAT_W   = 16;
  localparam int IDX_W   = 4;
  localparam int CNT_W_A = 5;
  localparam int TICK_A  = 1;
  localparam int CNT_W_B = 2;
  localparam int TICK_B  = 2;

  // clock / reset
  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  logic             start   = 1'b0;
  logic             sel_b   = 1'b0;
  logic [PAT_W-1:0] pattern = '0;
  logic [IDX_W:0]   length  = '0;
  logic             start_a, start_b;

  logic w_a, en_a, clr_a, busy_a, done_a, hv_a, det_a;
  logic [CNT_W_A-1:0] hc_a;
  logic [IDX_W-1:0]   fi_a;
  logic w_b, en_b, clr_b, busy_b, done_b, hv_b, det_b;
  logic [CNT_W_B-1:0] hc_b;
  logic [IDX_W-1:0]   fi_b;

  assign start_a = start & ~sel_b;
  assign start_b = start & sel_b;

  seq_stream_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W_A), .TICK_DIV(TICK_A), .IDX_W(IDX_W)) dut_a (
    .clock(clock), .resetn(resetn), .start(start_a), .pattern(pattern), .length(length),
    .det_out(det_a), .w(w_a), .det_en(en_a), .det_clr(clr_a), .busy(busy_a), .done(done_a),
    .hit_count(hc_a), .hit_valid(hv_a), .first_hit_idx(fi_a));

  seq_stream_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W_B), .TICK_DIV(TICK_B), .IDX_W(IDX_W)) dut_b (
    .clock(clock), .resetn(resetn), .start(start_b), .pattern(pattern), .length(length),
    .det_out(det_b), .w(w_b), .det_en(en_b), .det_clr(clr_b), .busy(busy_b), .done(done_b),
    .hit_count(hc_b), .hit_valid(hv_b), .first_hit_idx(fi_b));

  // Detector states 0..6 = A..G; output high in F (1111) and G (1101).
  function automatic int det_next(input int s, input logic b);
    case (s)
      0: return b ? 1 : 0;
      1: return b ? 2 : 0;
      2: return b ? 3 : 4;
      3: return b ? 5 : 4;
      4: return b ? 6 : 0;
      5: return b ? 5 : 4;
      6: return b ? 2 : 0;
      default: return 0;
    endcase
  endfunction

  int det_sa = 0;
  int det_sb = 0;
  always @(posedge clock) begin
    if (clr_a)     det_sa <= 0;
    else if (en_a) det_sa <= det_next(det_sa, w_a);
    if (clr_b)     det_sb <= 0;
    else if (en_b) det_sb <= det_next(det_sb, w_b);
  end
  assign det_a = (det_sa == 5) || (det_sa == 6);
  assign det_b = (det_sb == 5) || (det_sb == 6);

  logic m_w, m_en, m_clr, m_busy, m_done, m_hv;
  logic [CNT_W_A-1:0] m_hc;
  logic [IDX_W-1:0]   m_fi;
  assign m_w    = sel_b ? w_b    : w_a;
  assign m_en   = sel_b ? en_b   : en_a;
  assign m_clr  = sel_b ? clr_b  : clr_a;
  assign m_busy = sel_b ? busy_b : busy_a;
  assign m_done = sel_b ? done_b : done_a;
  assign m_hv   = sel_b ? hv_b   : hv_a;
  assign m_hc   = sel_b ? CNT_W_A'(hc_b) : hc_a;
  assign m_fi   = sel_b ? fi_b   : fi_a;

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: the detector fires on bit i when the last four played bits are 1111 or 1101.
  function automatic void model(input logic [PAT_W-1:0] pat, input int len, input int cmax,
                                output int lc, output int cnt, output int first, output int valid);
    int hits;
    logic [3:0] win;
    hits = 0; win = '0; first = 0; valid = 0;
    lc = (len > PAT_W) ? PAT_W : len;
    for (int i = 0; i < lc; i++) begin
      win = {win[2:0], pat[PAT_W-1-i]};
      if (i >= 3 && (win == 4'b1111 || win == 4'b1101)) begin
        if (valid == 0) begin valid = 1; first = i; end
        hits++;
      end
    end
    cnt = (hits > cmax) ? cmax : hits;
  endfunction

  // driver: one run on the selected instance, optionally poking start in SEND and DONE
  task automatic run_case(input string tag, input logic use_b, input logic [PAT_W-1:0] pat,
                          input int len, input bit poke);
    int lc, cnt, first, valid, td, cmax, lat, done_k, en_n, clr_n, both_n, busy_bad, extra;
    bit poked;
    logic [0:0] eb;
    td   = use_b ? TICK_B : TICK_A;
    cmax = use_b ? (1 << CNT_W_B) - 1 : (1 << CNT_W_A) - 1;
    model(pat, len, cmax, lc, cnt, first, valid);
    lat = (lc == 0) ? 1 : 2 + lc * (td + 1);
    exp_q.delete();
    for (int i = 0; i < lc; i++) exp_q.push_back(pat[PAT_W-1-i]);
    sel_b = use_b;
    @(negedge clock);
    pattern = pat;
    length  = (IDX_W+1)'(len);
    start   = 1'b1;
    done_k = -1; en_n = 0; clr_n = 0; both_n = 0; busy_bad = 0; poked = 0;
    for (int k = 1; k <= lat + 8 && done_k < 0; k++) begin
      @(negedge clock);
      start = 1'b0;
      if (k == 1) begin
        pattern = PAT_W'($urandom);
        length  = (IDX_W+1)'($urandom_range(0, 31));
      end
      if (m_en) begin
        en_n++;
        if (exp_q.size() > 0) begin
          eb = exp_q.pop_front();
          check({tag, "_w"}, 32'(m_w), 32'(eb));
        end
      end
      if (m_clr) clr_n++;
      if (m_en && m_clr) both_n++;
      if (m_busy !== (k < lat)) busy_bad++;
      if (poke && m_en && !poked) begin start = 1'b1; poked = 1; end
      if (m_done === 1'b1) begin
        done_k = k;
        if (poke) start = 1'b1;
      end
    end
    check({tag, "_latency"}, 32'(done_k), 32'(lat));
    check({tag, "_det_en_n"}, 32'(en_n), 32'(lc));
    check({tag, "_det_clr_n"}, 32'(clr_n), 32'(lc > 0));
    check({tag, "_en_clr_overlap"}, 32'(both_n), 32'd0);
    check({tag, "_busy"}, 32'(busy_bad), 32'd0);
    check({tag, "_hit_count"}, 32'(m_hc), 32'(cnt));
    check({tag, "_hit_valid"}, 32'(m_hv), 32'(valid));
    check({tag, "_first_hit"}, 32'(m_fi), 32'(first));
    extra = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      start = 1'b0;
      if (m_done !== 1'b0 || m_busy !== 1'b0) extra++;
    end
    check({tag, "_idle_after"}, 32'(extra), 32'd0);
    check({tag, "_hold"}, 32'({m_hc, m_hv, m_fi}),
          32'({CNT_W_A'(cnt), valid[0], IDX_W'(first)}));
  endtask

  initial begin
    int n, bad, hc_pre;
    // reset state
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_a", 32'({w_a, en_a, clr_a, busy_a, done_a, hv_a, hc_a, fi_a}), 32'd0);
    check("reset_b", 32'({w_b, en_b, clr_b, busy_b, done_b, hv_b, hc_b, fi_b}), 32'd0);
    resetn = 1'b1;
    @(negedge clock);

    // asynchronous reset in the middle of SEND
    sel_b = 1'b0;
    pattern = 16'hFF00; length = 5'd8; start = 1'b1;
    n = 0; hc_pre = 0;
    for (int k = 0; k < 40 && n < 6; k++) begin
      @(negedge clock);
      start = 1'b0;
      if (en_a) n++;
    end
    hc_pre = int'(hc_a);
    check("rst_pre_hits", 32'(hc_pre), 32'd2);
    #2 resetn = 1'b0;
    #1 check("rst_async_outs", 32'({w_a, en_a, clr_a, busy_a, done_a, hv_a, hc_a, fi_a}), 32'd0);
    bad = 0;
    repeat (3) begin
      @(negedge clock);
      if (done_a !== 1'b0 || busy_a !== 1'b0) bad++;
    end
    resetn = 1'b1;
    repeat (2) begin
      @(negedge clock);
      if (done_a !== 1'b0) bad++;
    end
    check("rst_no_done", 32'(bad), 32'd0);

    // directed cases
    run_case("after_rst", 1'b0, 16'hFF00, 8, 1'b0);
    run_case("p1101", 1'b0, 16'hD000, 4, 1'b0);
    run_case("ones6", 1'b0, 16'hFC00, 6, 1'b0);
    run_case("zeros8", 1'b0, 16'h0000, 8, 1'b0);
    run_case("len0", 1'b0, 16'hFFFF, 0, 1'b0);
    run_case("len20", 1'b0, PAT_W'($urandom), 20, 1'b0);
    run_case("poke_a", 1'b0, 16'hDB00, 7, 1'b1);
    run_case("len0_poke", 1'b0, 16'h1234, 0, 1'b1);
    run_case("sat_b", 1'b1, 16'hFFFF, 16, 1'b1);
    run_case("p1101_b", 1'b1, 16'hD000, 4, 1'b0);

    // randomized runs on both instances
    for (int r = 0; r < 16; r++) begin
      run_case($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), PAT_W'($urandom),
               int'($urandom_range(0, 20)), bit'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/seq_stream_ctrl.md
Name: seq_stream_ctrl

Overview:
- Sequences the team's serial sequence-detector FSM.
- On each start, it clears the detector and plays a latched bit pattern into the detector's w input, MSB first, one bit per tick.
- It samples the detector's Moore output after every bit, counts hits and records the position of the first hit.
- It sits between board switches/keys (or a test sequencer) and the detector, replacing manual SW/KEY stepping.

Parameters:
PAT_W, 16, maximum pattern length in bits
CNT_W, 5, width of hit counter (saturating)
TICK_DIV, 1, clock cycles w is held before each detector advance (>=1)
IDX_W, 4, width of bit index, ceil(log2(PAT_W))

Ports:
clock  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
start  input  1  request to play pattern; sampled only in IDLE
pattern  input  PAT_W  bits to play, MSB first; latched on accepted start
length  input  IDX_W+1  number of bits to play, 0..PAT_W; latched on accepted start
det_out  input  1  detector Moore output
w  output  1  serial bit to detector
det_en  output  1  one-cycle pulse: detector advances state on this edge
det_clr  output  1  one-cycle synchronous clear of detector to its start state
busy  output  1  high from the cycle after start is accepted until DONE
done  output  1  one-cycle pulse at end of run
hit_count  output  CNT_W  number of sampled det_out=1 in the last run
hit_valid  output  1  at least one hit in the last run
first_hit_idx  output  IDX_W  0-based bit index of the first hit; 0 when hit_valid=0

Behaviour:
- Reset (async, resetn=0):
  - State goes to IDLE.
  - All outputs are 0.
  - Shift register, remaining count, tick counter and bit index are cleared.
  - Reset takes effect mid-run with no done pulse.
- States: IDLE, CLEAR, SEND, SAMPLE, DONE.
- IDLE:
  - busy=0.
  - On start=1, latch pattern and length. length>PAT_W clamps to PAT_W.
  - Clear hit_count, hit_valid, first_hit_idx and bit index.
  - If latched length==0, go to DONE; otherwise go to CLEAR.
- CLEAR:
  - det_clr=1 for exactly one cycle; w=0.
  - Go to SEND with tick counter=0.
- SEND:
  - w = shift_reg[PAT_W-1], stable for the whole state.
  - Tick counter increments each cycle.
  - On the cycle where tick counter == TICK_DIV-1: det_en=1, then go to SAMPLE.
- SAMPLE (one cycle):
  - det_en=0; w holds the same bit.
  - Register det_out. If it is 1:
    - hit_count increments, saturating at 2^CNT_W-1.
    - If hit_valid was 0, set hit_valid=1 and first_hit_idx=bit index.
  - Shift register shifts left by 1 (fill 0); bit index increments; remaining decrements.
  - If remaining becomes 0, go to DONE; else go to SEND with tick counter=0.
- DONE:
  - done=1 for one cycle; busy=0 in this cycle.
  - Return to IDLE.
- Results (hit_count, hit_valid, first_hit_idx) hold until the next accepted start.
- Latency: accepted start to done pulse = 1 (CLEAR) + length*(TICK_DIV+1) + 1 cycles. For length==0, done occurs on the cycle after start.
- start while not in IDLE is ignored, including in DONE. start held high in IDLE re-triggers on the next IDLE cycle.
- pattern and length changes after acceptance have no effect on the current run.
- det_en and det_clr are never high in the same cycle. det_en pulses exactly once per played bit.

Test Plan:
- Bench uses the team's 7-state detector. Its output is high in F (after ...1111-type runs of three or more 1s then 1) and in G (after 1,1,0,1).
1. Reset mid-SEND: assert resetn=0 async between edges -> all outputs 0 immediately; no done pulse; next start runs normally.
2. TICK_DIV=1, length=4, pattern MSBs 1101 -> det_clr once; det_en pulses=4; hit_count=1, hit_valid=1, first_hit_idx=3; done exactly 10 cycles after start.
3. length=6, pattern MSBs 111111 -> hit_count=3, first_hit_idx=3; w sequence observed at the det_en pulses is 1,1,1,1,1,1.
4. length=8, pattern MSBs 00000000 -> hit_count=0, hit_valid=0, first_hit_idx=0; done after 18 cycles.
5. length=0 -> no det_clr and no det_en; done one cycle after start. length=20 with PAT_W=16 -> exactly 16 det_en pulses.
6. start pulsed during SEND and DONE -> ignored (single done pulse). CNT_W=2 with a 16-bit all-ones pattern -> hit_count saturates at 3.
